// File: rtl/inst_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_queue_pkg
//  Purpose  : Shared constants for the instruction fetch queue. Holds the
//             RV32 opcodes, the RVC quadrant/funct3 codes, the FSM state
//             encodings and the FIFO entry layout.
//  Revision : 1.0  initial release
// ============================================================================
package inst_fetch_queue_pkg;

    // 32-bit control-flow opcodes (inst[6:0])
    localparam logic [6:0] c_JAL_INS  = 7'b1101111;
    localparam logic [6:0] c_JALR_INS = 7'b1100111;
    localparam logic [6:0] c_B_INS    = 7'b1100011;

    // RVC quadrants (inst[1:0]); 2'b11 marks a 32-bit instruction
    localparam logic [1:0] c_RVC_Q0   = 2'b00;
    localparam logic [1:0] c_RVC_Q1   = 2'b01;
    localparam logic [1:0] c_RVC_Q2   = 2'b10;
    localparam logic [1:0] c_RVC_NONE = 2'b11;

    // RVC funct3 codes (inst[15:13])
    localparam logic [2:0] c_C_JAL_F3  = 3'b001;  // Q1, RV32 only
    localparam logic [2:0] c_C_J_F3    = 3'b101;  // Q1
    localparam logic [2:0] c_C_BEQZ_F3 = 3'b110;  // Q1
    localparam logic [2:0] c_C_BNEZ_F3 = 3'b111;  // Q1
    localparam logic [2:0] c_C_JR_F3   = 3'b100;  // Q2, shared by C.JR/C.JALR/C.MV/C.ADD

    // Fetch FSM state encodings
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WAIT      = 2'd1;
    localparam logic [1:0] c_ST_JALR_HOLD = 2'd2;

    // One FIFO slot as seen by the Decoder
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        isjump;
        logic [31:0] pred_pc;
    } fq_entry_t;

endpackage : inst_fetch_queue_pkg
`default_nettype wire

// File: rtl/inst_fetch_queue_fetch_predecode.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_predecode
//  Purpose  : Combinational pre-decoder. Classifies a fetched word (32-bit or
//             RVC) and computes the next fetch PC: direct jumps are taken,
//             branches follow the predictor, register jumps fall through.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_predecode
    import inst_fetch_queue_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic        jump,
    output logic        is_rvc,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        is_br,
    output logic        isjump,
    output logic [31:0] npc
);

    logic [1:0]  w_quad;
    logic [2:0]  w_cf3;
    logic [6:0]  w_op;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_cj;
    logic [31:0] w_imm_cb;
    logic        w_c_jal;
    logic        w_c_br;
    logic        w_c_jalr;

    assign w_quad = inst[1:0];
    assign w_cf3  = inst[15:13];
    assign w_op   = inst[6:0];
    assign is_rvc = (w_quad != c_RVC_NONE);

    // Sign-extended immediates for every PC-relative form
    assign w_imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign w_imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_imm_cj = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                       inst[2], inst[11], inst[5:3], 1'b0};
    assign w_imm_cb = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10],
                       inst[4:3], 1'b0};

    // RVC classes; C.JR/C.JALR need rs1 != 0 and rs2 == 0 (else C.MV/C.ADD/C.EBREAK)
    assign w_c_jal  = (w_quad == c_RVC_Q1) && ((w_cf3 == c_C_J_F3) || (w_cf3 == c_C_JAL_F3));
    assign w_c_br   = (w_quad == c_RVC_Q1) && ((w_cf3 == c_C_BEQZ_F3) || (w_cf3 == c_C_BNEZ_F3));
    assign w_c_jalr = (w_quad == c_RVC_Q2) && (w_cf3 == c_C_JR_F3) &&
                      (inst[11:7] != 5'd0) && (inst[6:2] == 5'd0);

    assign is_jal  = is_rvc ? w_c_jal  : (w_op == c_JAL_INS);
    assign is_jalr = is_rvc ? w_c_jalr : (w_op == c_JALR_INS);
    assign is_br   = is_rvc ? w_c_br   : (w_op == c_B_INS);
    assign isjump  = is_jal || (is_br && jump);

    // Next-PC selection: taken target or sequential fall-through
    always_comb begin
        npc = pc + (is_rvc ? 32'd2 : 32'd4);
        if (is_jal) begin
            npc = pc + (is_rvc ? w_imm_cj : w_imm_j);
        end else if (is_br && jump) begin
            npc = pc + (is_rvc ? w_imm_cb : w_imm_b);
        end
    end

endmodule : fetch_predecode
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_queue
//  Purpose  : Fetch stage with a QUEUE_DEPTH-entry instruction FIFO. Issues
//             one ICache request at a time, pre-decodes each hit to pick the
//             next PC, and buffers instructions toward the Decoder. A RoB
//             flush empties the queue and redirects fetch.
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter int          CNT_W       = $clog2(QUEUE_DEPTH) + 1,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    output logic             fetch_valid,
    output logic [31:0]      fetch_pc,
    input  logic             hit,
    input  logic [31:0]      hit_inst,
    output logic [31:0]      pc_to_pre,
    input  logic             jump,
    output logic             if_valid,
    output logic [31:0]      if_inst,
    output logic [31:0]      if_pc,
    output logic             if_isjump,
    output logic [31:0]      if_pred_pc,
    input  logic             dc_ready,
    input  logic             jalr_done,
    input  logic [31:0]      jalr_target,
    input  logic             rob_clear,
    input  logic [31:0]      rob_newpc,
    output logic [CNT_W-1:0] fq_count
);

    localparam int               c_PTR_W    = $clog2(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(QUEUE_DEPTH);

    logic [1:0]         r_state;
    logic [31:0]        r_pc;
    logic               r_fetch_valid;
    logic [31:0]        r_fetch_pc;
    fq_entry_t          r_mem [QUEUE_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_is_rvc;
    logic               w_is_jal;
    logic               w_is_jalr;
    logic               w_is_br;
    logic               w_isjump;
    logic [31:0]        w_npc;
    logic               w_push;
    logic               w_pop;
    fq_entry_t          w_new_entry;
    fq_entry_t          w_head;

    fetch_predecode u_predecode (
        .inst    (hit_inst),
        .pc      (r_pc),
        .jump    (jump),
        .is_rvc  (w_is_rvc),
        .is_jal  (w_is_jal),
        .is_jalr (w_is_jalr),
        .is_br   (w_is_br),
        .isjump  (w_isjump),
        .npc     (w_npc)
    );

    // A hit is only meaningful while our single request is outstanding
    assign w_push = !rst_in && !rob_clear && rdy_in && (r_state == c_ST_WAIT) && hit;
    assign w_pop  = !rst_in && !rob_clear && rdy_in && if_valid && dc_ready;

    assign w_new_entry = '{inst: hit_inst, pc: r_pc, isjump: w_isjump, pred_pc: w_npc};
    assign w_head      = r_mem[r_rd_ptr];

    assign fetch_valid = r_fetch_valid;
    assign fetch_pc    = r_fetch_pc;
    assign pc_to_pre   = r_fetch_pc;
    assign fq_count    = r_count;
    assign if_valid    = (r_count != '0);
    // Stale storage is masked so an empty queue presents all-zero head fields
    assign if_inst     = if_valid ? w_head.inst    : 32'h0;
    assign if_pc       = if_valid ? w_head.pc      : 32'h0;
    assign if_isjump   = if_valid ? w_head.isjump  : 1'b0;
    assign if_pred_pc  = if_valid ? w_head.pred_pc : 32'h0;

    // Pre-decode invariants: one control-flow class at most, untaken flow is sequential
    always_comb begin
        assert ($onehot0({w_is_jal, w_is_jalr, w_is_br}));
        assert (w_isjump || (w_npc == r_pc + (w_is_rvc ? 32'd2 : 32'd4)));
    end

    // FIFO storage write; contents need no reset since occupancy gates the head
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk_in) begin
        if (rst_in || rob_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Fetch FSM: issue when there is room, wait for the hit, park on register jumps
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= c_ST_IDLE;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= 32'h0;
        end else if (rob_clear) begin
            r_state       <= c_ST_IDLE;
            r_pc          <= rob_newpc;
            r_fetch_valid <= 1'b0;
        end else if (rdy_in) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_count < c_FULL_CNT) begin
                        r_fetch_valid <= 1'b1;
                        r_fetch_pc    <= r_pc;
                        r_state       <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (hit) begin
                        r_fetch_valid <= 1'b0;
                        r_pc          <= w_npc;
                        r_state       <= w_is_jalr ? c_ST_JALR_HOLD : c_ST_IDLE;
                    end
                end
                c_ST_JALR_HOLD: begin
                    if (jalr_done) begin
                        r_pc    <= jalr_target;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_fetch_valid <= 1'b0;
                    r_state       <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule : inst_fetch_queue
`default_nettype wire
